// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the PRBS generator/checker pair: state encoding,
// default feedback mask and the single step function both ends must agree on.
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  localparam int unsigned LFSR_MAX_W        = 32;
  localparam logic [7:0]  LFSR_TAPS_DEFAULT = 8'hB8;

  // Caller zero-extends x/taps to LFSR_MAX_W; bits at or above width are cleared.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] x,
    input logic [LFSR_MAX_W-1:0] taps,
    input int unsigned           width
  );
    logic [LFSR_MAX_W-1:0] r;
    r = {x[LFSR_MAX_W-2:0], ^(x & taps)};
    for (int unsigned i = 0; i < LFSR_MAX_W; i++) begin
      if (i >= width) r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Word stream into the checker plus its lock/error status back out.
interface lfsr_checker_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 enable;
  logic [WIDTH-1:0]     value;
  logic                 clear;
  logic                 locked;
  logic                 error;
  logic [CNT_WIDTH-1:0] err_count;

  modport master (output enable, value, clear, input locked, error, err_count);
  modport slave  (input enable, value, clear, output locked, error, err_count);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
// One-cycle latency; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/lfsr_checker.sv
// PRBS receive checker: hunts for a seed, confirms LOCK_COUNT predictions, then
// flywheels and flags mismatches. All outputs registered, one clock after the sample edge.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(LFSR_TAPS_DEFAULT),
  parameter int unsigned      LOCK_COUNT = 4,
  parameter int unsigned      LOSS_COUNT = 8,
  parameter int unsigned      CNT_WIDTH  = 16
) (
  input logic           clk,
  input logic           reset,
  lfsr_checker_if.slave bus
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned LW = $clog2(LOSS_COUNT + 1);

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
    return WIDTH'(lfsr_next(LFSR_MAX_W'(x), LFSR_MAX_W'(TAPS), WIDTH));
  endfunction

  lfsr_state_e      r_state,      w_state_nxt;
  logic [WIDTH-1:0] r_expected,   w_expected_nxt;
  logic [MW-1:0]    r_match_cnt,  w_match_nxt;
  logic [LW-1:0]    r_miss_cnt,   w_miss_nxt;
  logic             r_error,      w_error_nxt;
  logic             w_inc;
  logic             w_hit;
  logic [WIDTH-1:0] w_value_next;
  logic [CNT_WIDTH-1:0] w_err_count;

  assign w_hit        = (bus.value == r_expected);
  assign w_value_next = step(bus.value);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= HUNT;
      r_expected  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_expected  <= w_expected_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_error     <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_match_nxt    = r_match_cnt;
    w_miss_nxt     = r_miss_cnt;
    w_error_nxt    = 1'b0;
    w_inc          = 1'b0;
    if (bus.enable) begin
      case (r_state)
        HUNT: begin
          if (bus.value != '0) begin
            w_expected_nxt = w_value_next;
            w_match_nxt    = '0;
            w_state_nxt    = SYNC;
          end
        end
        SYNC: begin
          if (w_hit) begin
            w_expected_nxt = w_value_next;
            w_match_nxt    = r_match_cnt + MW'(1);
            if (r_match_cnt == MW'(LOCK_COUNT - 1)) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = '0;
            end
          end else if (bus.value != '0) begin
            w_expected_nxt = w_value_next;
            w_match_nxt    = '0;
          end else begin
            w_state_nxt = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: prediction ignores the received word so a single hit costs one error.
          w_expected_nxt = step(r_expected);
          if (w_hit) begin
            w_miss_nxt = '0;
          end else begin
            w_error_nxt = 1'b1;
            w_inc       = 1'b1;
            w_miss_nxt  = r_miss_cnt + LW'(1);
            if (r_miss_cnt == LW'(LOSS_COUNT - 1)) w_state_nxt = HUNT;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_inc),
    .i_clr (bus.clear),
    .o_cnt (w_err_count)
  );

  assign bus.locked    = (r_state == LOCKED);
  assign bus.error     = r_error;
  assign bus.err_count = w_err_count;

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side counterpart of the 8-bit LFSR pattern generator.
- Consumes the generator's parallel output one word per enabled cycle.
- Self-synchronises to the sequence, then flags and counts every word that deviates from the predicted next value.
- Sits at the far end of a link or datapath under test; used on-board and in benches as the pass/fail monitor for PRBS traffic.

Parameters:
- WIDTH, 8: LFSR/word width in bits.
- TAPS, 8'hB8: feedback mask (x^8+x^6+x^5+x^4, maximal length, period 255).
- LOCK_COUNT, 4: consecutive correct predictions required to declare lock.
- LOSS_COUNT, 8: consecutive mismatches while locked that force re-hunt.
- CNT_WIDTH, 16: error counter width.

Ports:
- clk  in  1  Rising-edge clock.
- reset  in  1  Asynchronous, active-low reset.
- enable  in  1  Word valid; value is sampled only when high.
- value  in  WIDTH  Received LFSR word.
- clear  in  1  Synchronous clear of err_count.
- locked  out  1  High while in LOCKED.
- error  out  1  One-cycle pulse per mismatched word while LOCKED.
- err_count  out  CNT_WIDTH  Saturating mismatch count.

Behaviour:
- Step function: next(x) = {x[WIDTH-2:0], ^(x & TAPS)}. This must be bit-identical to the generator.
- Reset (reset=0, asynchronous):
  - state=HUNT; expected, match_cnt, miss_cnt = 0.
  - Outputs: locked=0, error=0, err_count=0.
- Registered outputs: all outputs are registers updated on the same edge that samples value. Latency is one clock: the response is visible after that edge.
- enable=0: no state, counter or expected change; error=0 next cycle.
- HUNT, on enable:
  - value==0 (lock-up word): stay in HUNT.
  - Otherwise: expected<=next(value), match_cnt<=0, go to SYNC.
- SYNC, on enable:
  - value==expected: match_cnt++, expected<=next(value). When match_cnt reaches LOCK_COUNT, go to LOCKED and set miss_cnt<=0.
  - Mismatch, value!=0: reseed with expected<=next(value), match_cnt<=0, stay in SYNC.
  - Mismatch, value==0: go to HUNT.
  - error is never asserted outside LOCKED.
- LOCKED, on enable (flywheel):
  - expected<=next(expected) every enabled word, so one corrupted word produces exactly one error.
  - Match: miss_cnt<=0.
  - Mismatch: error=1, err_count++ (saturates at all-ones), miss_cnt++.
  - When miss_cnt reaches LOSS_COUNT: go to HUNT, locked<=0 on that same edge.
- clear: err_count<=0. If clear coincides with an increment, clear wins and the result is 0. clear has no effect on state.
- Reset mid-operation: immediate return to reset values regardless of state; no partial updates.
- WIDTH/TAPS combinations that are not maximal length are legal; lock behaviour is then sequence-dependent.

Decomposition:
- Shared package lfsr_pkg, also used by the generator:
  - state enum {HUNT, SYNC, LOCKED};
  - default TAPS constant;
  - lfsr_next function.
- One small sub-module, sat_counter (parameterised width, inc/clr, clear priority), instantiated for err_count.
- The rest is a single FSM process plus the compare logic.

Test Plan:
- Clean lock: seed 8'h01, stream 01,02,04,08,11,23,... with enable=1 → locked rises after the 5th sample edge; error stays 0; err_count stays 0 for 300 words, including wrap past period 255.
- Single-bit error: locked, then one word XOR 8'h10 → exactly one error pulse, err_count=1, locked stays 1; following words match again because expected is flywheel-driven.
- Loss of sync: locked, then 8 consecutive words of 8'hA5 → 8 error pulses, err_count=8, locked falls on the 8th; resumed valid stream relocks after 5 more enabled words.
- Gaps and zero word: enable toggled 1-0-1 during lock → no errors and no state advance on idle cycles; in HUNT, value 8'h00 with enable=1 → remains HUNT, locked=0.
- Saturation and clear: force 70000 mismatches (relocking as needed) → err_count holds 16'hFFFF. Then clear asserted on the same edge as a mismatch → err_count=0.
- Async reset: assert reset low mid-LOCKED, between clock edges → locked, error and err_count read 0 immediately; after release, a valid stream relocks after 5 words.
